// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction bundle hand-off and branch redirect bus between
//               the fetch unit (master) and the control unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ins_valid;
    logic              ins_ready;
    logic [7:0]        ins_opcode;
    logic [DATA_W-1:0] ins_operand;
    logic              ins_has_operand;
    logic [ADDR_W-1:0] ins_pc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;

    modport master (
        output ins_valid, ins_opcode, ins_operand, ins_has_operand, ins_pc,
        input  ins_ready, br_taken, br_target
    );

    modport slave (
        input  ins_valid, ins_opcode, ins_operand, ins_has_operand, ins_pc,
        output ins_ready, br_taken, br_target
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetches one- or two-word instructions from a synchronous
//               instruction memory and hands them off over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              halted,
    instr_fetch_if.master     ins
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_OP   = 3'd2;
    localparam logic [2:0] c_ST_ARG  = 3'd3;
    localparam logic [2:0] c_ST_OUT  = 3'd4;
    localparam logic [2:0] c_ST_HALT = 3'd5;

    localparam logic [7:0] c_OP_LOADIM = 8'd38;
    localparam logic [7:0] c_OP_JUMPZ  = 8'd41;
    localparam logic [7:0] c_OP_JUMPNZ = 8'd48;
    localparam logic [7:0] c_OP_JUMP   = 8'd49;
    localparam logic [7:0] c_OP_ENDOP  = 8'd51;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic              r_has_op;
    logic              w_two_word;

    // Only meaningful in OP, where imem_data holds the opcode word.
    assign w_two_word = (imem_data[7:0] == c_OP_LOADIM) ||
                        (imem_data[7:0] == c_OP_JUMPZ)  ||
                        (imem_data[7:0] == c_OP_JUMPNZ) ||
                        (imem_data[7:0] == c_OP_JUMP);

    always_comb begin
        w_next_state = r_state;
        imem_addr    = r_pc;
        case (r_state)
            c_ST_IDLE: if (start) w_next_state = c_ST_REQ;
            c_ST_REQ:  w_next_state = c_ST_OP;
            c_ST_OP: begin
                if (w_two_word) begin
                    imem_addr    = r_pc + ADDR_W'(1);
                    w_next_state = c_ST_ARG;
                end else begin
                    w_next_state = c_ST_OUT;
                end
            end
            c_ST_ARG:  w_next_state = c_ST_OUT;
            c_ST_OUT: begin
                if (ins.ins_ready) begin
                    w_next_state = (r_opcode == c_OP_ENDOP) ? c_ST_HALT : c_ST_REQ;
                end
            end
            c_ST_HALT: if (start) w_next_state = c_ST_REQ;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_has_op  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_IDLE: r_pc <= '0;
                c_ST_OP: begin
                    r_opcode  <= imem_data[7:0];
                    r_operand <= '0;
                    r_has_op  <= 1'b0;
                end
                c_ST_ARG: begin
                    r_operand <= imem_data;
                    r_has_op  <= 1'b1;
                end
                c_ST_OUT: begin
                    // endop keeps pc on itself and ignores any redirect.
                    if (ins.ins_ready && (r_opcode != c_OP_ENDOP)) begin
                        if (ins.br_taken) begin
                            r_pc <= ins.br_target;
                        end else begin
                            r_pc <= r_pc + (r_has_op ? ADDR_W'(2) : ADDR_W'(1));
                        end
                    end
                end
                c_ST_HALT: if (start) r_pc <= '0;
                default: ;
            endcase
        end
    end

    assign ins.ins_valid       = (r_state == c_ST_OUT);
    assign ins.ins_opcode      = r_opcode;
    assign ins.ins_operand     = r_operand;
    assign ins.ins_has_operand = r_has_op;
    assign ins.ins_pc          = r_pc;
    assign halted              = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly downstream of the instruction memory. It drives the memory read address from a program counter and absorbs the memory's one-cycle synchronous read latency. It assembles one- or two-word instructions (opcode word plus optional operand word) and hands each complete instruction to the control unit over a valid/ready handshake, accepting branch redirects at hand-off.

## Interface
- ADDR_W, 16, program counter / memory address width
- DATA_W, 16, instruction word width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin fetching from address 0 (sampled in IDLE or HALT only)
- imem_addr  out  ADDR_W  read address to instruction memory (combinational from state and pc)
- imem_data  in  DATA_W  instruction memory read data, valid the cycle after imem_addr is presented
- ins_valid  out  1  instruction bundle valid
- ins_ready  in  1  control unit accepts bundle
- ins_opcode  out  8  imem_data[7:0] of the opcode word
- ins_operand  out  DATA_W  second word for two-word opcodes, else 0
- ins_has_operand  out  1  bundle carries an operand word
- ins_pc  out  ADDR_W  address of the opcode word
- br_taken  in  1  redirect request, sampled only on handshake cycle
- br_target  in  ADDR_W  redirect address
- halted  out  1  endop (51) handed off, fetch stopped

## Operation
- States: IDLE, REQ, OP, ARG, OUT, HALT.
- IDLE: pc held at 0; start=1 -> REQ.
- REQ: imem_addr=pc -> OP.
- OP: imem_data = word at pc; latch opcode register = imem_data[7:0]; clear operand register. Two-word opcodes are loadim (38), jumpz (41), jumpnz (48), jump (49).
  - Two-word: imem_addr=pc+1 -> ARG.
  - Otherwise: imem_addr=pc -> OUT.
- ARG: latch operand = imem_data, has_operand=1 -> OUT.
- OUT: ins_valid=1; bundle registers frozen; imem_addr=pc. Handshake = ins_valid & ins_ready.
  - On handshake, br_taken=1: pc <= br_target.
  - On handshake, br_taken=0: pc <= pc + (has_operand ? 2 : 1), mod 2^ADDR_W.
  - On handshake, opcode=51: pc unchanged, -> HALT; endop takes precedence over br_taken.
  - Otherwise on handshake -> REQ.
  - No handshake: stay in OUT.
- HALT: halted=1, ins_valid=0; start=1 -> pc <= 0, halted <= 0, -> REQ.
- start is ignored in REQ/OP/ARG/OUT.
- Unknown opcodes are passed through as single-word; opcode upper byte is discarded.
- Block never writes memory; the loader owns write_en.

## Timing
- Reset: state IDLE, pc=0, ins_valid=0, ins_opcode=0, ins_operand=0, ins_has_operand=0, ins_pc=0, halted=0, imem_addr=0.
- Reset mid-operation (any state) aborts the in-flight instruction with no partial bundle; start is required again.
- Single-word latency: start sampled at edge E0 -> ins_valid high after E2. Two-word: after E3.
- Back-to-back throughput: handshake at edge H -> next ins_valid after H+2 (single-word) or H+3 (two-word).
- While ins_valid=1 and ins_ready=0, all ins_* outputs are stable.
- ins_valid may only fall after handshake or reset.
- Address arithmetic wraps: pc=0xFFFF, two-word: operand fetched from 0x0000, next pc=0x0001.

## Test plan
- Memory holding program words 38, 257, 9, 16 -> after start: bundles (pc 0, op 38, operand 0x0101, has_op 1), then (pc 2, op 9, operand 0, has_op 0), then (pc 3, op 16); ins_valid first high 3 cycles after start is sampled.
- Bundle at pc 111 = jump (49) with operand 3, br_taken=1, br_target=3 at handshake -> next ins_pc=3; no bundle issued for pc 113.
- Hold ins_ready=0 for 5 cycles on a loadim bundle -> ins_valid stays 1 and opcode/operand/pc are unchanged; it is accepted on the first ready cycle.
- endop (51) at pc 121 handed off -> halted=1 the next cycle, ins_valid=0, imem_addr constant; start -> halted=0, refetch from pc 0.
- rst=1 asserted during ARG of loadim at pc 6 -> all outputs at reset values the next cycle and the FSM stays IDLE without start.
- pc preset via branch to 0xFFFF holding loadim (38), word 0x0000 = 5 -> bundle operand 5, next ins_pc=0x0001.
